// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a bouncy button and accepts a level change only after
// DEBOUNCE_CYCLES equal samples; emits rise/fall pulses and a press count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_btn,
  output logic       o_btn,
  output logic       o_rise,
  output logic       o_fall,
  output logic [7:0] o_press_cnt
);
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic s1_q, s2_q, btn_q, btn_d, rise_q, rise_d, fall_q, fall_d;
  logic [7:0] press_q, press_d;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      STABLE_LO: begin
        state_d = s2_q ? PEND_HI : STABLE_LO;
        cnt_d = s2_q ? ONE : '0;
      end
      PEND_HI: begin
        state_d = !s2_q ? STABLE_LO : (cnt_q == LAST) ? STABLE_HI : PEND_HI;
        cnt_d = (state_d == PEND_HI) ? cnt_q + ONE : '0;
      end
      STABLE_HI: begin
        state_d = !s2_q ? PEND_LO : STABLE_HI;
        cnt_d = !s2_q ? ONE : '0;
      end
      PEND_LO: begin
        state_d = s2_q ? STABLE_HI : (cnt_q == LAST) ? STABLE_LO : PEND_LO;
        cnt_d = (state_d == PEND_LO) ? cnt_q + ONE : '0;
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d = '0;
      end
    endcase
    // Pulses are registered so they line up with the first cycle of the new level.
    rise_d = state_q == PEND_HI && state_d == STABLE_HI;
    fall_d = state_q == PEND_LO && state_d == STABLE_LO;
    btn_d = state_d == STABLE_HI || state_d == PEND_LO;
    press_d = press_q + 8'(rise_d);
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q <= '0;
      btn_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      press_q <= '0;
    end else begin
      s1_q <= i_btn;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      btn_q <= btn_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      press_q <= press_d;
    end
  end
  assign o_btn = btn_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_press_cnt = press_q;
endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, meaning the number of consecutive equal synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter: CNT_W, default 16, meaning the stability counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 Port i_clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_reset, input, 1 bit: asynchronous, active-low reset; low forces the reset state immediately, independent of i_clock.
REQ-005 Port i_btn, input, 1 bit: raw, asynchronous, bouncy button level.
REQ-006 Port o_btn, output, 1 bit: debounced, synchronous level; it feeds the downstream 1010 sequence detector bit input.
REQ-007 Port o_rise, output, 1 bit: one-cycle pulse on an accepted 0->1 change of o_btn.
REQ-008 Port o_fall, output, 1 bit: one-cycle pulse on an accepted 1->0 change of o_btn.
REQ-009 Port o_press_cnt, output, 8 bits: count of accepted presses (o_rise events), modulo 256.

Function
REQ-010 i_btn SHALL pass through a 2-flop synchronizer (s1, s2) before any other use; only s2 drives the FSM.
REQ-011 The FSM SHALL have exactly four states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-012 STABLE_LO SHALL behave as follows: if s2=1, go to PEND_HI and load cnt=1; otherwise hold, with cnt=0.
REQ-013 PEND_HI SHALL behave as follows: if s2=0, return to STABLE_LO and clear cnt (glitch rejected, no output change); if s2=1 and cnt=DEBOUNCE_CYCLES-1, go to STABLE_HI and clear cnt; otherwise increment cnt.
REQ-014 STABLE_HI and PEND_LO SHALL mirror REQ-012 and REQ-013 with the polarity of s2 inverted.
REQ-015 o_btn SHALL be 1 exactly in STABLE_HI and PEND_LO, and 0 in STABLE_LO and PEND_HI; it SHALL be registered, with no combinational path from i_btn.
REQ-016 Latency: with i_btn stable after it is first sampled at rising edge k, o_btn SHALL change after edge k+DEBOUNCE_CYCLES+1 (after edge k+5 for the default).
REQ-017 A level held for DEBOUNCE_CYCLES-1 or fewer synchronized samples SHALL never change o_btn, o_rise, o_fall, or o_press_cnt.
REQ-018 o_rise SHALL be high for exactly the one cycle after the PEND_HI->STABLE_HI transition; o_fall SHALL be high for exactly the one cycle after the PEND_LO->STABLE_LO transition.
REQ-019 o_rise and o_fall SHALL never both be high in the same cycle, and each SHALL coincide with the first cycle of the new o_btn level.
REQ-020 o_press_cnt SHALL increment by 1 in the same cycle o_rise asserts, and SHALL wrap from 255 to 0 with no flag.
REQ-021 cnt SHALL never exceed DEBOUNCE_CYCLES-1, and SHALL be 0 in both STABLE states.

Reset
REQ-022 While i_reset=0, the block SHALL hold s1=s2=0, state=STABLE_LO, cnt=0, o_btn=0, o_rise=0, o_fall=0, o_press_cnt=0.
REQ-023 Reset asserted in any state, including PEND_HI or PEND_LO, SHALL discard partial progress with no o_rise or o_fall pulse.
REQ-024 After i_reset deasserts while i_btn=1, the block SHALL require a full debounce (REQ-016) before o_btn=1, and SHALL then pulse o_rise and count the press.

Verification
Bench conditions: 10 ns clock, DEBOUNCE_CYCLES=4, stimulus changes away from rising edges.
REQ-025 Reset check: i_reset=0 for 25 ns with i_btn toggling -> all outputs 0 throughout.
REQ-026 Clean press and release:
- i_btn=1 for 20 cycles, first sampled at edge k -> o_btn=1 after edge k+5, o_rise high for that one cycle only, o_press_cnt=1.
- i_btn then 0 -> o_fall pulses after 5 edges, o_press_cnt stays 1.
REQ-027 Glitch boundary:
- 3-cycle high pulse -> o_btn stays 0, o_press_cnt unchanged.
- Exactly 4-cycle high pulse -> o_btn=1 for 4 cycles, one o_rise pulse, one o_fall pulse.
REQ-028 Bounce train: 1,0,1,1,0,1,1,1,1,1 (one value per cycle) -> exactly one o_rise, asserted after the fifth consecutive 1 is sampled.
REQ-029 Reset mid-PEND_HI (cnt=2) -> outputs 0 immediately, no pulse; after release with i_btn held 1 -> o_rise 5 edges later.
REQ-030 Wrap: 256 clean presses from reset -> o_press_cnt reads 255 after the 255th press and 0 after the 256th.
